// File: rtl/sdp_block_ram.sv
// Simple dual-port block RAM: one write port with byte enables and one read port.
// An INIT/RUN sequencer zeroes every word after reset. OUT_REG selects 1- or 2-cycle
// read latency. Optional macro SDP_RAM_BYPASS_EN gives write-first behaviour on a
// same-address read/write; without it the read returns the old stored word.
module sdp_block_ram #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RAM_WIDTH  = 8,
  parameter int unsigned RAM_DEPTH  = 16,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wen_i,
  input  logic [ADDR_WIDTH-1:0]  waddr_i,
  input  logic [RAM_WIDTH/8-1:0] wbe_i,
  input  logic [RAM_WIDTH-1:0]   wdata_i,
  input  logic                   ren_i,
  input  logic [ADDR_WIDTH-1:0]  raddr_i,
  output logic [RAM_WIDTH-1:0]   rdata_o,
  output logic                   rvalid_o,
  output logic                   init_busy_o
);

  localparam int unsigned             NumBytes = RAM_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]     DepthExt = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0]   LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  logic [RAM_WIDTH-1:0]    mem_q [RAM_DEPTH];

  logic                    wr_in_range, rd_in_range;
  logic                    wr_fire, rd_fire;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [NumBytes-1:0]     mem_be;
  logic [RAM_WIDTH-1:0]    mem_wdata;
  logic [RAM_WIDTH-1:0]    rd1_d, rd1_q;
  logic                    rv1_d, rv1_q;

  // Sequencer next state: walk the clear counter through every word, then run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Sequencer state register; reset restarts the clear sequence from word 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy_o = (state_q == StInit);
  assign wr_in_range = ({1'b0, waddr_i} < DepthExt);
  assign rd_in_range = ({1'b0, raddr_i} < DepthExt);
  assign wr_fire     = (state_q == StRun) && wen_i && wr_in_range;
  assign rd_fire     = (state_q == StRun) && ren_i;

  // Memory write port mux: clear writes during INIT, user writes during RUN.
  always_comb begin
    mem_we    = wr_fire;
    mem_addr  = waddr_i;
    mem_be    = wbe_i;
    mem_wdata = wdata_i;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_be    = '1;
      mem_wdata = '0;
    end
  end

  // Storage array; left unreset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (mem_be[i]) mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Read word selection; out-of-range reads return zero.
  always_comb begin
    rd1_d = rd_in_range ? mem_q[raddr_i] : '0;
    rv1_d = rd_fire;
`ifdef SDP_RAM_BYPASS_EN
    // Same-edge write to the read address forwards the enabled lanes.
    if (wr_fire && (waddr_i == raddr_i)) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (wbe_i[i]) rd1_d[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
`endif
  end

  // First read stage: data only updates on an accepted read so rdata holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
    end else begin
      rv1_q <= rv1_d;
      if (rd_fire) rd1_q <= rd1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [RAM_WIDTH-1:0] rd2_q;
    logic                 rv2_q;

    // Optional output stage, reset so an in-flight read is dropped on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd2_q <= '0;
        rv2_q <= 1'b0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q) rd2_q <= rd1_q;
      end
    end

    assign rdata_o  = rd2_q;
    assign rvalid_o = rv2_q;
  end else begin : g_no_out_reg
    assign rdata_o  = rd1_q;
    assign rvalid_o = rv1_q;
  end

endmodule

// File: tb/tb_sdp_block_ram.sv
// Directed bench for sdp_block_ram. Two instances share stimulus:
// dut_a: 8-bit, 16 words, OUT_REG=0; dut_b: 32-bit, 12 words, OUT_REG=1.
module tb_sdp_block_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  waddr = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] wdata = '0;
  logic        ren = 1'b0;
  logic [3:0]  raddr = '0;

  logic [7:0]  rdata_a;
  logic        rvalid_a, busy_a;
  logic [31:0] rdata_b;
  logic        rvalid_b, busy_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_coll_a;
  logic [31:0] exp_coll_b;

  always #5 clk = ~clk;

  sdp_block_ram #(
    .ADDR_WIDTH(4), .RAM_WIDTH(8), .RAM_DEPTH(16), .OUT_REG(0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .wen_i(wen), .waddr_i(waddr), .wbe_i(wbe[0:0]),
    .wdata_i(wdata[7:0]), .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata_a),
    .rvalid_o(rvalid_a), .init_busy_o(busy_a)
  );

  sdp_block_ram #(
    .ADDR_WIDTH(4), .RAM_WIDTH(32), .RAM_DEPTH(12), .OUT_REG(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .wen_i(wen), .waddr_i(waddr), .wbe_i(wbe),
    .wdata_i(wdata), .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .init_busy_o(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; wbe = '0; wdata = '0; waddr = '0; raddr = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (rdata_a !== 8'h00) begin errors++; $display("FAIL reset_rdata_a got %h exp 00", rdata_a); end
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL reset_rvalid_a got %b exp 0", rvalid_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy_a got %b exp 1", busy_a); end
    checks++; if (rdata_b !== 32'h0) begin errors++; $display("FAIL reset_rdata_b got %h exp 0", rdata_b); end
    checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL reset_rvalid_b got %b exp 0", rvalid_b); end
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL reset_busy_b got %b exp 1", busy_b); end
  endtask

  // Releases reset and measures INIT length; requests during INIT must be ignored.
  task automatic test_init(input string tag);
    int first_a = 0, first_b = 0, bad_a = 0, bad_b = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      // Edges E0..E11: both instances still clearing, so this write must be dropped.
      wen = (i <= 12); waddr = 4'd2; wbe = 4'hF; wdata = 32'hFFFF_FFFF;
      ren = 1'b1; raddr = 4'd2;
      tick();
      if (rvalid_a && i <= 16) bad_a++;
      if (rvalid_b && i <= 12) bad_b++;
      if (!busy_a && first_a == 0) first_a = i;
      if (!busy_b && first_b == 0) first_b = i;
      if (first_a != 0 && first_b != 0) break;
    end
    idle();
    tick(); tick(); tick();
    checks++; if (first_a != 16) begin errors++; $display("FAIL %s_len_a got %0d exp 16", tag, first_a); end
    checks++; if (first_b != 12) begin errors++; $display("FAIL %s_len_b got %0d exp 12", tag, first_b); end
    checks++; if (bad_a != 0) begin errors++; $display("FAIL %s_rvalid_a got %0d exp 0", tag, bad_a); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL %s_rvalid_b got %0d exp 0", tag, bad_b); end
  endtask

  task automatic test_init_readback();
    for (int i = 0; i <= 16; i++) begin
      ren = (i < 16); raddr = 4'(i);
      tick();
      if (i < 16) begin
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== 8'h00) begin
          errors++; $display("FAIL zero_a[%0d] got v=%b d=%h exp v=1 d=00", i, rvalid_a, rdata_a);
        end
      end
      if (i >= 1) begin
        checks++;
        if (rvalid_b !== 1'b1 || rdata_b !== 32'h0) begin
          errors++; $display("FAIL zero_b[%0d] got v=%b d=%h exp v=1 d=0", i - 1, rvalid_b, rdata_b);
        end
      end
    end
    idle(); tick(); tick();
  endtask

  task automatic test_byte_enables();
    wen = 1'b1; waddr = 4'd3; wbe = 4'b1111; wdata = 32'hAABB_CCDD; tick();
    wen = 1'b1; waddr = 4'd3; wbe = 4'b0101; wdata = 32'h1122_3344; tick();
    idle(); ren = 1'b1; raddr = 4'd3; tick();
    ren = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 8'h44) begin
      errors++; $display("FAIL be_a got v=%b d=%h exp v=1 d=44", rvalid_a, rdata_a); end
    checks++; if (rvalid_b !== 1'b0) begin
      errors++; $display("FAIL be_b_early got v=%b exp v=0", rvalid_b); end
    tick();
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== 32'hAA22_CC44) begin
      errors++; $display("FAIL be_b got v=%b d=%h exp v=1 d=aa22cc44", rvalid_b, rdata_b); end
    tick();
  endtask

  task automatic test_latency();
    ren = 1'b1; raddr = 4'd3; tick();
    ren = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || rvalid_b !== 1'b0) begin
      errors++; $display("FAIL lat_edge_n got a=%b b=%b exp a=1 b=0", rvalid_a, rvalid_b); end
    tick();
    checks++; if (rvalid_a !== 1'b0 || rdata_a !== 8'h44) begin
      errors++; $display("FAIL lat_hold_a got v=%b d=%h exp v=0 d=44", rvalid_a, rdata_a); end
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== 32'hAA22_CC44) begin
      errors++; $display("FAIL lat_b got v=%b d=%h exp v=1 d=aa22cc44", rvalid_b, rdata_b); end
    tick();
    checks++; if (rvalid_b !== 1'b0 || rdata_b !== 32'hAA22_CC44) begin
      errors++; $display("FAIL lat_hold_b got v=%b d=%h exp v=0 d=aa22cc44", rvalid_b, rdata_b); end
  endtask

  task automatic test_back_to_back();
    int tot_a = 0, run_a = 0, max_a = 0, tot_b = 0, run_b = 0, max_b = 0;
    for (int k = 0; k < 12; k++) begin
      ren = (k < 8); raddr = 4'(k);
      tick();
      if (rvalid_a) begin tot_a++; run_a++; if (run_a > max_a) max_a = run_a; end else run_a = 0;
      if (rvalid_b) begin tot_b++; run_b++; if (run_b > max_b) max_b = run_b; end else run_b = 0;
    end
    idle();
    checks++; if (tot_a != 8 || max_a != 8) begin
      errors++; $display("FAIL b2b_a got tot=%0d run=%0d exp 8/8", tot_a, max_a); end
    checks++; if (tot_b != 8 || max_b != 8) begin
      errors++; $display("FAIL b2b_b got tot=%0d run=%0d exp 8/8", tot_b, max_b); end
  endtask

  task automatic test_collision();
    wen = 1'b1; waddr = 4'd5; wbe = 4'b0001; wdata = 32'h0000_000F; tick();
    wen = 1'b1; waddr = 4'd5; wbe = 4'b0001; wdata = 32'h0000_00F0;
    ren = 1'b1; raddr = 4'd5; tick();
    idle();
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== exp_coll_a) begin
      errors++; $display("FAIL coll_a got v=%b d=%h exp v=1 d=%h", rvalid_a, rdata_a, exp_coll_a); end
    tick();
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== exp_coll_b) begin
      errors++; $display("FAIL coll_b got v=%b d=%h exp v=1 d=%h", rvalid_b, rdata_b, exp_coll_b); end
    // The colliding write is visible to the very next read.
    ren = 1'b1; raddr = 4'd5; tick();
    ren = 1'b0;
    checks++; if (rdata_a !== 8'hF0) begin
      errors++; $display("FAIL coll_after_a got %h exp f0", rdata_a); end
    tick();
    checks++; if (rdata_b !== 32'h0000_00F0) begin
      errors++; $display("FAIL coll_after_b got %h exp 000000f0", rdata_b); end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [7:0]  am [16];
    logic [31:0] bm [16];
    for (int i = 0; i < 16; i++) begin am[i] = 8'h00; bm[i] = 32'h0; end
    am[3] = 8'h44; am[5] = 8'hF0; am[13] = 8'h5A;
    bm[3] = 32'hAA22_CC44; bm[5] = 32'h0000_00F0;
    // Address 13 is beyond dut_b's 12 words but inside dut_a's 16.
    wen = 1'b1; waddr = 4'd13; wbe = 4'hF; wdata = 32'h0000_005A; tick();
    // Zero byte enables: no-op write.
    wen = 1'b1; waddr = 4'd7; wbe = 4'h0; wdata = 32'hFFFF_FFFF; tick();
    idle();
    ren = 1'b1; raddr = 4'd3; tick();
    ren = 1'b1; raddr = 4'd13; tick();
    ren = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 8'h5A) begin
      errors++; $display("FAIL oor_a13 got v=%b d=%h exp v=1 d=5a", rvalid_a, rdata_a); end
    tick();
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== 32'h0) begin
      errors++; $display("FAIL oor_b13 got v=%b d=%h exp v=1 d=0", rvalid_b, rdata_b); end
    for (int i = 0; i <= 16; i++) begin
      ren = (i < 16); raddr = 4'(i);
      tick();
      if (i < 16) begin
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== am[i]) begin
          errors++; $display("FAIL sweep_a[%0d] got v=%b d=%h exp v=1 d=%h", i, rvalid_a, rdata_a, am[i]);
        end
      end
      if (i >= 1) begin
        checks++;
        if (rvalid_b !== 1'b1 || rdata_b !== bm[i-1]) begin
          errors++; $display("FAIL sweep_b[%0d] got v=%b d=%h exp v=1 d=%h", i - 1, rvalid_b, rdata_b,
                             bm[i-1]);
        end
      end
    end
    idle(); tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    int stray = 0;
    ren = 1'b1; raddr = 4'd3; tick();
    ren = 1'b1; raddr = 4'd3; tick();
    ren = 1'b0;
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== 32'hAA22_CC44) begin
      errors++; $display("FAIL mid_pre_b got v=%b d=%h exp v=1 d=aa22cc44", rvalid_b, rdata_b); end
    // Second read is still in dut_b's pipeline when reset hits.
    rst_n = 1'b0;
    #1;
    checks++; if (rvalid_b !== 1'b0 || rdata_b !== 32'h0) begin
      errors++; $display("FAIL mid_clr_b got v=%b d=%h exp v=0 d=0", rvalid_b, rdata_b); end
    checks++; if (rvalid_a !== 1'b0 || rdata_a !== 8'h00 || busy_a !== 1'b1) begin
      errors++; $display("FAIL mid_clr_a got v=%b d=%h busy=%b exp 0/00/1", rvalid_a, rdata_a, busy_a); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rvalid_b) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_stray_b got %0d exp 0", stray); end
    test_init("reinit");
    ren = 1'b1; raddr = 4'd3; tick();
    ren = 1'b1; raddr = 4'd13; 
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 8'h00) begin
      errors++; $display("FAIL reinit_a3 got v=%b d=%h exp v=1 d=00", rvalid_a, rdata_a); end
    tick();
    ren = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 8'h00) begin
      errors++; $display("FAIL reinit_a13 got v=%b d=%h exp v=1 d=00", rvalid_a, rdata_a); end
    checks++; if (rvalid_b !== 1'b1 || rdata_b !== 32'h0) begin
      errors++; $display("FAIL reinit_b3 got v=%b d=%h exp v=1 d=0", rvalid_b, rdata_b); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SDP_RAM_BYPASS_EN
    exp_coll_a = 8'hF0;
    exp_coll_b = 32'h0000_00F0;
`else
    exp_coll_a = 8'h0F;
    exp_coll_b = 32'h0000_000F;
`endif
    test_reset();
    test_init("init");
    test_init_readback();
    test_byte_enables();
    test_latency();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
